adler32_checksum: RTL and testbench

//   Streaming Adler-32 checksum engine (RFC 1950).
//   - A message length is announced first, then the message bytes arrive one per clock.
//   - Returns the 32-bit checksum {B,A} with a one-cycle valid pulse.
//   - Sits between a byte-stream source and any integrity-check or compare logic.

---
 rtl/adler32_pkg.sv | 31 +++
 rtl/adler32_if.sv | 21 ++
 rtl/adler32_mod_acc.sv | 17 +
 rtl/adler32_checksum.sv | 112 +++++++++++
 tb/tb_adler32_checksum.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adler32_pkg.sv
// Shared widths, FSM state encodings and the Adler-32 per-byte update.
package adler32_pkg;

  localparam int unsigned SIZE_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 16;

  localparam logic [16:0] ADLER_MOD = 17'd65521;

  // FSM state encodings
  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] DATA       = 2'd2;
  localparam logic [1:0] DONE       = 2'd3;

  // One byte of Adler-32: returns {B', A'}; both sums stay below 2*M so one subtract suffices
  function automatic logic [31:0] adler_step(input logic [SUM_W-1:0]  a,
                                             input logic [SUM_W-1:0]  b,
                                             input logic [DATA_W-1:0] din);
    logic [16:0]       a_sum;
    logic [16:0]       b_sum;
    logic [SUM_W-1:0]  a_new;
    logic [SUM_W-1:0]  b_new;
    a_sum = 17'(a) + 17'(din);
    a_new = (a_sum >= ADLER_MOD) ? 16'(a_sum - ADLER_MOD) : a_sum[15:0];
    b_sum = 17'(b) + 17'(a_new);
    b_new = (b_sum >= ADLER_MOD) ? 16'(b_sum - ADLER_MOD) : b_sum[15:0];
    return {b_new, a_new};
  endfunction

endpackage

// File: rtl/adler32_if.sv
// Byte-stream in / checksum out bundle for the Adler-32 engine.
interface adler32_if;
  import adler32_pkg::*;

  logic              size_valid;
  logic [SIZE_W-1:0] size;
  logic              data_start;
  logic [DATA_W-1:0] data;
  logic              checksum_valid;
  logic [31:0]       checksum;

  modport master (
    output size_valid, size, data_start, data,
    input  checksum_valid, checksum
  );

  modport slave (
    input  size_valid, size, data_start, data,
    output checksum_valid, checksum
  );
endinterface

// File: rtl/adler32_mod_acc.sv
// Combinational A/B update with single-subtract modulo reduction.
module adler32_mod_acc
  import adler32_pkg::*;
(
  input  logic [SUM_W-1:0]  a_i,
  input  logic [SUM_W-1:0]  b_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [SUM_W-1:0]  a_c,
  output logic [SUM_W-1:0]  b_c
);

  // Next A/B for the byte on din_i
  always_comb begin
    {b_c, a_c} = adler_step(a_i, b_i, din_i);
  end

endmodule

// File: rtl/adler32_checksum.sv
// Streaming Adler-32 engine: size strobe, then one byte per clock, then a
// one-cycle checksum pulse. Optional busy output under ADLER32_BUSY_EN.
module adler32_checksum
  import adler32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
`ifdef ADLER32_BUSY_EN
  output logic       busy,
`endif
  adler32_if.slave   bus
);

  logic [1:0]        state_q, state_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]  a_q, a_d;
  logic [SUM_W-1:0]  b_q, b_d;
  logic [31:0]       checksum_q, checksum_d;
  logic              checksum_valid_q, checksum_valid_d;
  logic [SUM_W-1:0]  a_c, b_c;
`ifdef ADLER32_BUSY_EN
  logic              busy_q, busy_d;
`endif

  adler32_mod_acc u_mod_acc (
    .a_i   (a_q),
    .b_i   (b_q),
    .din_i (bus.data),
    .a_c   (a_c),
    .b_c   (b_c)
  );

  // Next-state, counter and accumulator update; a new size always restarts
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    a_d              = a_q;
    b_d              = b_q;
    checksum_d       = checksum_q;
    checksum_valid_d = 1'b0;

    if (bus.size_valid) begin
      cnt_d   = bus.size;
      a_d     = 16'd1;
      b_d     = 16'd0;
      state_d = (bus.size == 32'd0) ? DONE : WAIT_START;
    end else begin
      case (state_q)
        WAIT_START: begin
          if (bus.data_start) begin
            a_d     = a_c;
            b_d     = b_c;
            cnt_d   = cnt_q - 32'd1;
            state_d = (cnt_q == 32'd1) ? DONE : DATA;
          end
        end
        DATA: begin
          a_d     = a_c;
          b_d     = b_c;
          cnt_d   = cnt_q - 32'd1;
          state_d = (cnt_q == 32'd1) ? DONE : DATA;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    checksum_valid_d = (state_d == DONE);
    if (checksum_valid_d) begin
      checksum_d = {b_d, a_d};
    end
  end

`ifdef ADLER32_BUSY_EN
  // Busy whenever a message is in flight or its result is being presented
  always_comb begin
    busy_d = (state_d != IDLE);
  end
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      a_q              <= 16'd1;
      b_q              <= 16'd0;
      checksum_q       <= '0;
      checksum_valid_q <= 1'b0;
`ifdef ADLER32_BUSY_EN
      busy_q           <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      a_q              <= a_d;
      b_q              <= b_d;
      checksum_q       <= checksum_d;
      checksum_valid_q <= checksum_valid_d;
`ifdef ADLER32_BUSY_EN
      busy_q           <= busy_d;
`endif
    end
  end

  assign bus.checksum_valid = checksum_valid_q;
  assign bus.checksum       = checksum_q;
`ifdef ADLER32_BUSY_EN
  assign busy               = busy_q;
`endif

endmodule

// File: tb/tb_adler32_checksum.sv
// Self-checking bench for adler32_checksum: scoreboard of expected checksums
// popped by a monitor on each checksum_valid pulse.
module tb_adler32_checksum;

  typedef logic [7:0] bq_t[$];

  logic clk;
  logic rst;
`ifdef ADLER32_BUSY_EN
  logic busy;
`endif

  adler32_if bus_if ();

  adler32_checksum dut (
    .clk  (clk),
    .rst  (rst),
`ifdef ADLER32_BUSY_EN
    .busy (busy),
`endif
    .bus  (bus_if)
  );

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Adler-32 using plain modulo arithmetic
  function automatic logic [31:0] sw_adler(input bq_t msg);
    int unsigned a;
    int unsigned b;
    a = 1;
    b = 0;
    foreach (msg[i]) begin
      a = (a + 32'(msg[i])) % 65521;
      b = (b + a) % 65521;
    end
    return {b[15:0], a[15:0]};
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && bus_if.checksum_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: checksum=%08h with no result outstanding at %0t",
                 bus_if.checksum, $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus_if.checksum !== e) begin
          errors++;
          $display("FAIL checksum: got %08h expected %08h at %0t", bus_if.checksum, e, $time);
        end
      end
    end
  end

  // Drive one message; entered and left on a negedge. On return the
  // checksum_valid pulse for this message should be visible.
  task automatic send_msg(input bq_t msg, input int gap);
    bus_if.size_valid = 1'b1;
    bus_if.size       = 32'(msg.size());
    bus_if.data_start = 1'b0;
    bus_if.data       = 8'($urandom);
    @(negedge clk);
    bus_if.size_valid = 1'b0;
    if (msg.size() == 0) return;
    repeat (gap) begin
      bus_if.data = 8'($urandom);
      @(negedge clk);
    end
    foreach (msg[i]) begin
      bus_if.data       = msg[i];
      bus_if.data_start = (i == 0);
      @(negedge clk);
    end
    bus_if.data_start = 1'b0;
    bus_if.data       = 8'($urandom);
  endtask

  // Bounded wait for the scoreboard to empty
  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.size_valid = 1'b0;
    bus_if.size       = '0;
    bus_if.data_start = 1'b0;
    bus_if.data       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_if.checksum_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b required 0", bus_if.checksum_valid);
    end
    checks++;
    if (bus_if.checksum !== 32'h0) begin
      errors++;
      $display("FAIL reset_checksum: got %08h required 00000000", bus_if.checksum);
    end
`ifdef ADLER32_BUSY_EN
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
`endif
    // data_start in IDLE must not start anything
    bus_if.data_start = 1'b1;
    bus_if.data       = 8'h5A;
    repeat (3) @(negedge clk);
    bus_if.data_start = 1'b0;
  endtask

  task automatic test_size_zero();
    bq_t empty;
    exp_q.push_back(32'h0000_0001);
    send_msg(empty, 0);
    checks++;
    if (bus_if.checksum_valid !== 1'b1 || bus_if.checksum !== 32'h0000_0001) begin
      errors++;
      $display("FAIL size0_latency: valid=%b checksum=%08h required valid=1 checksum=00000001",
               bus_if.checksum_valid, bus_if.checksum);
    end
    @(negedge clk);
    wait_drain("size0");
  endtask

  task automatic test_vectors();
    exp_q.push_back(32'h0062_0062);
    send_msg(str2q("a"), 0);
    checks++;
    if (bus_if.checksum_valid !== 1'b1) begin
      errors++;
      $display("FAIL a_latency: valid=%b required 1", bus_if.checksum_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.checksum !== 32'h0062_0062 || bus_if.checksum_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold: checksum=%08h valid=%b required 00620062 valid=0",
               bus_if.checksum, bus_if.checksum_valid);
    end
    exp_q.push_back(32'h024D_0127);
    send_msg(str2q("abc"), 2);
    checks++;
    if (bus_if.checksum_valid !== 1'b1) begin
      errors++;
      $display("FAIL abc_latency: valid=%b required 1", bus_if.checksum_valid);
    end
    @(negedge clk);
    exp_q.push_back(32'h11E6_0398);
    send_msg(str2q("Wikipedia"), 1);
    checks++;
    if (bus_if.checksum_valid !== 1'b1) begin
      errors++;
      $display("FAIL wiki_latency: valid=%b required 1", bus_if.checksum_valid);
    end
    @(negedge clk);
    wait_drain("vectors");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'h024D_0127);
    send_msg(str2q("abc"), 0);
    checks++;
    if (bus_if.checksum_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: valid=%b required 1", bus_if.checksum_valid);
    end
    exp_q.push_back(32'h0062_0062);
    send_msg(str2q("a"), 0);
    checks++;
    if (bus_if.checksum_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: valid=%b required 1", bus_if.checksum_valid);
    end
    @(negedge clk);
    wait_drain("b2b");
  endtask

  task automatic test_size_abort();
    // New size mid-message discards the partial message
    bus_if.size_valid = 1'b1;
    bus_if.size       = 32'd5;
    @(negedge clk);
    bus_if.size_valid = 1'b0;
    bus_if.data_start = 1'b1;
    bus_if.data       = 8'h11;
    @(negedge clk);
    bus_if.data_start = 1'b0;
    bus_if.data       = 8'h22;
    @(negedge clk);
    exp_q.push_back(32'h024D_0127);
    send_msg(str2q("abc"), 0);
    @(negedge clk);
    // Largest size: counter must not wrap; abort after a few bytes
    bus_if.size_valid = 1'b1;
    bus_if.size       = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_if.size_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_if.data_start = (i == 0);
      bus_if.data       = 8'($urandom);
      @(negedge clk);
    end
    bus_if.data_start = 1'b0;
    checks++;
    if (bus_if.checksum_valid !== 1'b0) begin
      errors++;
      $display("FAIL maxsize_early: valid=%b required 0", bus_if.checksum_valid);
    end
`ifdef ADLER32_BUSY_EN
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_data: got %b required 1", busy);
    end
`endif
    exp_q.push_back(32'h0062_0062);
    send_msg(str2q("a"), 0);
    @(negedge clk);
    wait_drain("abort");
  endtask

  task automatic test_wrap_600();
    bq_t msg;
    repeat (600) msg.push_back(8'hFF);
    exp_q.push_back(sw_adler(msg));
    send_msg(msg, 0);
    checks++;
    if (bus_if.checksum_valid !== 1'b1) begin
      errors++;
      $display("FAIL ff600_latency: valid=%b required 1", bus_if.checksum_valid);
    end
    @(negedge clk);
    wait_drain("ff600");
  endtask

  task automatic test_reset_abort();
    bus_if.size_valid = 1'b1;
    bus_if.size       = 32'd600;
    @(negedge clk);
    bus_if.size_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus_if.data_start = (i == 0);
      bus_if.data       = 8'hFF;
      @(negedge clk);
    end
    bus_if.data_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_if.checksum !== 32'h0) begin
      errors++;
      $display("FAIL rst_abort_checksum: got %08h required 00000000", bus_if.checksum);
    end
    for (int i = 0; i < 20; i++) begin
      bus_if.data = 8'hFF;
      @(negedge clk);
      checks++;
      if (bus_if.checksum_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_abort_quiet: cycle %0d valid=%b required 0", i, bus_if.checksum_valid);
      end
    end
    exp_q.push_back(32'h0062_0062);
    send_msg(str2q("a"), 0);
    @(negedge clk);
    wait_drain("rst_abort");
  endtask

  task automatic test_random();
    for (int m = 0; m < 10; m++) begin
      bq_t msg;
      int  len;
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      exp_q.push_back(sw_adler(msg));
      send_msg(msg, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    wait_drain("random");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus_if.size_valid = 1'b0;
    bus_if.size       = '0;
    bus_if.data_start = 1'b0;
    bus_if.data       = '0;
    @(negedge clk);
    test_reset();
    test_size_zero();
    test_vectors();
    test_back_to_back();
    test_size_abort();
    test_wrap_600();
    test_reset_abort();
    test_random();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
